// File: rtl/rr_priority_encoder_if.sv
// ---------------------------------------------------------------------------
// rr_priority_encoder_if
//   Handshake bundle for the round-robin / fixed-priority set-bit encoder.
//
//   Parameters
//     N       request vector width
//     IDXW    index width, derived as clog2(N)
//
//   Signals
//     in_vec    request vector, bit k = source k requesting
//     in_rr     mode for this vector: 0 fixed priority, 1 round-robin
//     in_valid  in_vec / in_rr valid
//     in_ready  encoder can accept a vector
//     out_idx   index of the set bit being emitted
//     out_zero  captured vector had no bits set
//     out_last  final beat for the captured vector
//     out_valid out_idx / out_zero / out_last valid
//     out_ready consumer accepts the current beat
//
//   Modports
//     master  producer + consumer side (drives in_*, out_ready)
//     slave   the encoder itself
// ---------------------------------------------------------------------------
interface rr_priority_encoder_if #(
    parameter int N = 8
);
    localparam int IDXW = $clog2(N);

    logic [N-1:0]    in_vec;
    logic            in_rr;
    logic            in_valid;
    logic            in_ready;
    logic [IDXW-1:0] out_idx;
    logic            out_zero;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output in_vec,
        output in_rr,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_idx,
        input  out_zero,
        input  out_last,
        input  out_valid
    );

    modport slave (
        input  in_vec,
        input  in_rr,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_idx,
        output out_zero,
        output out_last,
        output out_valid
    );
endinterface

// File: rtl/rr_priority_encoder.sv
// ---------------------------------------------------------------------------
// rr_priority_encoder
//   Captures a request vector and emits the index of every set bit, one
//   beat per cycle, over a valid/ready stream. Each vector chooses its own
//   ordering: fixed priority (highest index first) or round-robin (descending
//   from a persistent pointer, wrapping from 0 to N-1). A vector with no bits
//   set produces a single beat flagged out_zero.
//
//   Parameters
//     N       request vector width, legal 2..64 (must match the bus N)
//
//   Ports
//     clk     single clock, rising edge
//     rst_n   synchronous active-low reset
//     bus     rr_priority_encoder_if.slave handshake bundle
//
//   Timing
//     First beat appears the cycle after accept; all outputs come straight
//     from flops. in_ready returns the cycle after the last beat handshake.
// ---------------------------------------------------------------------------
module rr_priority_encoder #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rr_priority_encoder_if.slave  bus
);
    localparam int IDXW = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // One output beat: the selected index plus its flags.
    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic            zero;
        logic            last;
    } beat_t;

    // Selects the next index to emit from vec. Fixed mode starts the
    // descending search at N-1; round-robin starts at ptr (inclusive) and
    // wraps. last is set for a one-hot or empty vector.
    function automatic beat_t pick(
        input logic [N-1:0]    vec,
        input logic            rr,
        input logic [IDXW-1:0] ptr
    );
        beat_t           b;
        int              start;
        int              k;
        logic [IDXW-1:0] kk;
        logic            found;
        b.idx  = {IDXW{1'b0}};
        b.zero = (vec == {N{1'b0}});
        b.last = b.zero || ((vec & (vec - N'(1))) == {N{1'b0}});
        found  = 1'b0;
        start  = rr ? int'(ptr) : (N - 1);
        for (int i = 0; i < N; i++) begin
            k  = (start >= i) ? (start - i) : (start + N - i);
            kk = IDXW'(k);
            if (!found && vec[kk]) begin
                found = 1'b1;
                b.idx = kk;
            end else begin
                found = found;
            end
        end
        return b;
    endfunction

    state_t          state_r,   state_nxt_s;
    logic [N-1:0]    pending_r, pending_nxt_s;
    logic            mode_r,    mode_nxt_s;
    logic [IDXW-1:0] ptr_r,     ptr_nxt_s;
    logic [IDXW-1:0] idx_r,     idx_nxt_s;
    logic            zero_r,    zero_nxt_s;
    logic            last_r,    last_nxt_s;

    logic [N-1:0]    cleared_s;
    logic [IDXW-1:0] ptr_step_s;
    logic [IDXW-1:0] ptr_adv_s;
    beat_t           acc_beat_s;
    beat_t           nxt_beat_s;

    // Candidate beats: one for a freshly accepted vector, one for the vector
    // remaining after the current beat is consumed (pointer already advanced).
    always_comb begin
        cleared_s  = pending_r & ~({{(N-1){1'b0}}, 1'b1} << idx_r);
        ptr_step_s = (idx_r == {IDXW{1'b0}}) ? IDXW'(N - 1) : (idx_r - IDXW'(1));
        // A zero-vector beat leaves the round-robin pointer where it was.
        ptr_adv_s  = (mode_r && !zero_r) ? ptr_step_s : ptr_r;
        acc_beat_s = pick(bus.in_vec, bus.in_rr, ptr_r);
        nxt_beat_s = pick(cleared_s, mode_r, ptr_adv_s);
    end

    // Next-state and next-output logic for the IDLE/EMIT controller.
    always_comb begin
        state_nxt_s   = state_r;
        pending_nxt_s = pending_r;
        mode_nxt_s    = mode_r;
        ptr_nxt_s     = ptr_r;
        idx_nxt_s     = idx_r;
        zero_nxt_s    = zero_r;
        last_nxt_s    = last_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nxt_s   = EMIT;
                    pending_nxt_s = bus.in_vec;
                    mode_nxt_s    = bus.in_rr;
                    idx_nxt_s     = acc_beat_s.idx;
                    zero_nxt_s    = acc_beat_s.zero;
                    last_nxt_s    = acc_beat_s.last;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EMIT: begin
                // in_valid is deliberately not looked at here.
                if (bus.out_ready) begin
                    pending_nxt_s = cleared_s;
                    ptr_nxt_s     = ptr_adv_s;
                    if (last_r) begin
                        state_nxt_s = IDLE;
                        idx_nxt_s   = {IDXW{1'b0}};
                        zero_nxt_s  = 1'b0;
                        last_nxt_s  = 1'b0;
                    end else begin
                        idx_nxt_s  = nxt_beat_s.idx;
                        zero_nxt_s = nxt_beat_s.zero;
                        last_nxt_s = nxt_beat_s.last;
                    end
                end else begin
                    // Backpressure: everything holds.
                    state_nxt_s = EMIT;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                pending_nxt_s = {N{1'b0}};
                mode_nxt_s    = 1'b0;
                idx_nxt_s     = {IDXW{1'b0}};
                zero_nxt_s    = 1'b0;
                last_nxt_s    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            pending_r <= {N{1'b0}};
            mode_r    <= 1'b0;
            ptr_r     <= IDXW'(N - 1);
            idx_r     <= {IDXW{1'b0}};
            zero_r    <= 1'b0;
            last_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pending_r <= pending_nxt_s;
            mode_r    <= mode_nxt_s;
            ptr_r     <= ptr_nxt_s;
            idx_r     <= idx_nxt_s;
            zero_r    <= zero_nxt_s;
            last_r    <= last_nxt_s;
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == EMIT);
    assign bus.out_idx   = idx_r;
    assign bus.out_zero  = zero_r;
    assign bus.out_last  = last_r;

endmodule
